fir_mac_seq: RTL and testbench

- Parametrised, time-multiplexed FIR filter; next generation of the team's 5-tap direct-form filter.
- Loads TAPS coefficients serially, then filters unsigned samples using a single shared multiplier-accumulator, one tap per clock.
- Adds output scaling, saturation, a busy indication and overrun detection.
- Sits between the sample source and the downstream consumer on a single clock domain.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_mac_seq_if.sv | 9 +
 rtl/fir_mac_acc.sv | 36 +++
 rtl/fir_mac_seq.sv | 93 +++++++++
 tb/tb_fir_mac_seq.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM states, width helpers and saturation for the sequential FIR
package fir_pkg;
  typedef enum logic [2:0] {S_IDLE, S_COEF, S_FILT, S_MAC, S_ERR} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int accw(input int dw, input int taps);
    return 2 * dw + clog2(taps);
  endfunction
  function automatic logic [63:0] sat(input logic [63:0] v, input int ow);
    logic [63:0] m = (64'd1 << ow) - 64'd1;
    return v > m ? m : v;
  endfunction
endpackage

// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if: sample/coefficient input and filtered result output bundle
interface fir_mac_seq_if #(parameter int DW = 8, parameter int OW = 16);
  logic [DW-1:0] data_in;
  logic coef_enable, sample_enable;
  logic [OW-1:0] data_out;
  logic out_enable, busy, error;
  modport master(output data_in, coef_enable, sample_enable, input data_out, out_enable, busy, error);
  modport slave(input data_in, coef_enable, sample_enable, output data_out, out_enable, busy, error);
endinterface

// File: rtl/fir_mac_acc.sv
// fir_mac_acc: shared multiplier-accumulator with output shift, saturation and result register
module fir_mac_acc import fir_pkg::*; #(
  parameter int DW = 8,
  parameter int TAPS = 5,
  parameter int OW = 16,
  parameter int SHIFT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic last,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] h,
  output logic [OW-1:0] result
);
  localparam int ACCW = accw(DW, TAPS);
  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] acc, sum, sh;
  // product of the current tap added to the running sum, then scaled
  always_comb begin
    prod = {{DW{1'b0}}, x} * {{DW{1'b0}}, h};
    sum = acc + {{(ACCW-2*DW){1'b0}}, prod};
    sh = sum >> SHIFT;
  end
  // accumulate one tap per enabled cycle; latch the saturated result on the last tap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc <= '0;
      result <= '0;
    end else begin
      if (clear) acc <= '0;
      else if (enable) acc <= sum;
      if (enable && last) result <= OW'(sat(64'(sh), OW));
    end
endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR with serial coefficient load, saturation and overrun detection
module fir_mac_seq import fir_pkg::*; #(
  parameter int TAPS = 5,
  parameter int DW = 8,
  parameter int OW = 16,
  parameter int SHIFT = 0
) (
  input logic clk,
  input logic reset,
  fir_mac_seq_if.slave bus
);
  localparam int CW = clog2(TAPS);
  localparam logic [CW-1:0] LAST = CW'(TAPS - 1);
  state_t state;
  logic [DW-1:0] h [TAPS];
  logic [DW-1:0] x [TAPS];
  logic [CW-1:0] cnt;
  logic ce, se, accept, step;
  assign ce = bus.coef_enable;
  assign se = bus.sample_enable;
  assign accept = state == S_FILT && se && !ce;
  assign step = state == S_MAC && !se && !ce;
  fir_mac_acc #(.DW(DW), .TAPS(TAPS), .OW(OW), .SHIFT(SHIFT)) u_mac (
    .clk(clk), .reset(reset), .clear(accept), .enable(step), .last(cnt == LAST),
    .x(x[cnt]), .h(h[cnt]), .result(bus.data_out)
  );
  // control FSM owning coefficient and history files, tap counter and status flags
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      bus.out_enable <= 1'b0;
      bus.busy <= 1'b0;
      bus.error <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        h[i] <= '0;
        x[i] <= '0;
      end
    end else begin
      bus.out_enable <= 1'b0;
      case (state)
        S_IDLE:
          if (se) begin
            state <= S_ERR;
            bus.error <= 1'b1;
          end else if (ce) begin
            h[0] <= bus.data_in;
            cnt <= CW'(1);
            state <= S_COEF;
          end
        S_COEF:
          if (se || !ce) begin
            state <= S_ERR;
            bus.error <= 1'b1;
          end else begin
            h[cnt] <= bus.data_in;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              cnt <= '0;
              state <= S_FILT;
            end
          end
        S_FILT:
          if (se && ce) begin
            state <= S_ERR;
            bus.error <= 1'b1;
          end else if (se) begin
            x[0] <= bus.data_in;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            cnt <= '0;
            bus.busy <= 1'b1;
            state <= S_MAC;
          end else if (ce) begin
            h[0] <= bus.data_in;
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            cnt <= CW'(1);
            state <= S_COEF;
          end
        S_MAC:
          if (se || ce) begin
            bus.busy <= 1'b0;
            bus.error <= 1'b1;
            state <= S_ERR;
          end else if (cnt == LAST) begin
            cnt <= '0;
            bus.busy <= 1'b0;
            bus.out_enable <= 1'b1;
            state <= S_FILT;
          end else cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed and random checks of two filter instances (SHIFT 0 and 2) against a sum-of-products model
module tb_fir_mac_seq;
  logic clk = 0, reset = 0;
  logic [7:0] d = 0;
  logic ce = 0, se = 0;
  int n = 0, fails = 0;
  int hm[5], xm[5];
  int md0 = 0, md1 = 0;
  always #5 clk = ~clk;
  fir_mac_seq_if #(.DW(8), .OW(16)) b0 ();
  fir_mac_seq_if #(.DW(8), .OW(16)) b1 ();
  assign b0.data_in = d;
  assign b0.coef_enable = ce;
  assign b0.sample_enable = se;
  assign b1.data_in = d;
  assign b1.coef_enable = ce;
  assign b1.sample_enable = se;
  fir_mac_seq #(.TAPS(5), .DW(8), .OW(16), .SHIFT(0)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  fir_mac_seq #(.TAPS(5), .DW(8), .OW(16), .SHIFT(2)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic oe, input logic bz, input logic er);
    chk({tag, ".oe0"}, {31'd0, b0.out_enable}, {31'd0, oe});
    chk({tag, ".busy0"}, {31'd0, b0.busy}, {31'd0, bz});
    chk({tag, ".err0"}, {31'd0, b0.error}, {31'd0, er});
    chk({tag, ".dout0"}, {16'd0, b0.data_out}, md0);
    chk({tag, ".oe1"}, {31'd0, b1.out_enable}, {31'd0, oe});
    chk({tag, ".busy1"}, {31'd0, b1.busy}, {31'd0, bz});
    chk({tag, ".err1"}, {31'd0, b1.error}, {31'd0, er});
    chk({tag, ".dout1"}, {16'd0, b1.data_out}, md1);
  endtask

  function automatic int satv(input longint v);
    return v > 65535 ? 65535 : int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 0;
    #1;
    md0 = 0;
    md1 = 0;
    foreach (hm[i]) begin
      hm[i] = 0;
      xm[i] = 0;
    end
    chk_all(tag, 0, 0, 0);
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic load(input int c[5]);
    for (int k = 0; k < 5; k++) begin
      d = 8'(c[k]);
      ce = 1;
      tick();
    end
    ce = 0;
    foreach (hm[i]) begin
      hm[i] = c[i];
      xm[i] = 0;
    end
    chk_all("load", 0, 0, 0);
  endtask

  task automatic sample(input int v);
    longint sum = 0;
    d = 8'(v);
    se = 1;
    tick();
    se = 0;
    for (int i = 4; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = v;
    foreach (xm[i]) sum += longint'(xm[i]) * longint'(hm[i]);
    chk_all("mac", 0, 1, 0);
    repeat (4) begin
      tick();
      chk_all("mac", 0, 1, 0);
    end
    tick();
    md0 = satv(sum);
    md1 = satv(sum >>> 2);
    chk_all("out", 1, 0, 0);
  endtask

  initial begin
    int c[5];
    do_reset("reset");
    load('{1, 2, 3, 4, 5});
    sample(10);
    sample(20);
    load('{0, 0, 0, 0, 1});
    sample(7);
    do_reset("reset2");
    load('{255, 255, 255, 255, 255});
    repeat (5) sample(255);
    do_reset("reset3");
    load('{1, 2, 3, 4, 5});
    sample(100);
    foreach (c[i]) c[i] = int'($urandom_range(0, 255));
    load(c);
    repeat (12) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk_all("idle", 0, 0, 0);
      end
      sample(int'($urandom_range(0, 255)));
    end
    sample(50);
    d = 10;
    se = 1;
    tick();
    se = 0;
    tick();
    se = 1;
    tick();
    se = 0;
    chk_all("overrun", 0, 0, 1);
    repeat (6) begin
      tick();
      chk_all("overrun_hold", 0, 0, 1);
    end
    do_reset("reset4");
    for (int k = 1; k <= 3; k++) begin
      d = 8'(k);
      ce = 1;
      tick();
    end
    ce = 0;
    chk_all("coef3", 0, 0, 0);
    tick();
    chk_all("coef_err", 0, 0, 1);
    se = 1;
    tick();
    chk_all("err_se", 0, 0, 1);
    se = 0;
    ce = 1;
    tick();
    chk_all("err_ce", 0, 0, 1);
    se = 1;
    tick();
    chk_all("err_both", 0, 0, 1);
    se = 0;
    ce = 0;
    do_reset("err_clear");
    load('{1, 2, 3, 4, 5});
    sample(30);
    d = 9;
    se = 1;
    tick();
    se = 0;
    tick();
    tick();
    do_reset("reset_mac");
    repeat (8) begin
      tick();
      chk_all("after_reset", 0, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
